// File: rtl/nn_argmax_stream.sv
// Streaming argmax over one frame of class scores: tracks best and second-best,
// then holds the winning index, score and top-1/top-2 margin behind valid/ready.
module nn_argmax_stream #(
   parameter int NUM_CLASSES = 10,
   parameter int SCORE_W     = 16,
   parameter int IDX_W       = 4,
   parameter bit SIGNED      = 1'b1,
   parameter bit TIE_LAST    = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [SCORE_W-1:0] score_data,
   input  logic               score_valid,
   input  logic               score_last,
   output logic               score_ready,
   output logic [IDX_W-1:0]   class_out,
   output logic [SCORE_W-1:0] max_score,
   output logic [SCORE_W:0]   margin,
   output logic               len_err,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [15:0]        frame_cnt
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_t;

   state_t               r_state, w_state_n;
   logic                 r_score_ready, r_out_valid;
   logic [IDX_W-1:0]     r_cnt, r_best_idx, r_class_out;
   logic [SCORE_W-1:0]   r_best, r_second, r_max_score;
   logic                 r_second_valid, r_len_err;
   logic [SCORE_W:0]     r_margin;
   logic [15:0]          r_frame_cnt;

   logic                 w_accept, w_is_last_idx, w_frame_end, w_replace;
   logic [SCORE_W-1:0]   w_best_n, w_sec_n;
   logic [IDX_W-1:0]     w_idx_n;
   logic                 w_secv_n;
   logic [SCORE_W:0]     w_ext_best, w_ext_sec, w_margin;

   function automatic logic f_gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
      if (SIGNED) return $signed(a) > $signed(b);
      else        return a > b;
   endfunction

   function automatic logic f_ge(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
      if (SIGNED) return $signed(a) >= $signed(b);
      else        return a >= b;
   endfunction

   assign w_accept      = (r_state == ACC) && score_valid;
   assign w_is_last_idx = (r_cnt == LAST_IDX);
   assign w_frame_end   = w_accept && (score_last || w_is_last_idx);
   assign w_replace     = TIE_LAST ? f_ge(score_data, r_best) : f_gt(score_data, r_best);

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         ACC:     if (w_frame_end) w_state_n = DONE;
         DONE:    if (out_ready)   w_state_n = ACC;
         default: w_state_n = ACC;
      endcase
   end

   // Best/second as they stand after the current beat, so frame-end results include it.
   always_comb begin
      w_best_n = r_best;
      w_idx_n  = r_best_idx;
      w_sec_n  = r_second;
      w_secv_n = r_second_valid;
      if (r_cnt == '0) begin
         w_best_n = score_data;
         w_idx_n  = '0;
         w_secv_n = 1'b0;
      end else if (w_replace) begin
         w_sec_n  = r_best;
         w_secv_n = 1'b1;
         w_best_n = score_data;
         w_idx_n  = r_cnt;
      end else if (!r_second_valid || f_gt(score_data, r_second)) begin
         w_sec_n  = score_data;
         w_secv_n = 1'b1;
      end
   end

   assign w_ext_best = SIGNED ? {w_best_n[SCORE_W-1], w_best_n} : {1'b0, w_best_n};
   assign w_ext_sec  = SIGNED ? {w_sec_n[SCORE_W-1], w_sec_n}   : {1'b0, w_sec_n};
   assign w_margin   = w_secv_n ? (w_ext_best - w_ext_sec) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ACC;
         r_score_ready  <= 1'b1;
         r_out_valid    <= 1'b0;
         r_cnt          <= '0;
         r_best         <= '0;
         r_best_idx     <= '0;
         r_second       <= '0;
         r_second_valid <= 1'b0;
         r_class_out    <= '0;
         r_max_score    <= '0;
         r_margin       <= '0;
         r_len_err      <= 1'b0;
         r_frame_cnt    <= '0;
      end else begin
         r_state       <= w_state_n;
         r_score_ready <= (w_state_n == ACC);
         r_out_valid   <= (w_state_n == DONE);
         if (w_accept) begin
            r_best         <= w_best_n;
            r_best_idx     <= w_idx_n;
            r_second       <= w_sec_n;
            r_second_valid <= w_secv_n;
            r_cnt          <= w_frame_end ? '0 : r_cnt + IDX_ONE;
         end
         if (w_frame_end) begin
            r_class_out <= w_idx_n;
            r_max_score <= w_best_n;
            r_margin    <= w_margin;
            r_len_err   <= (score_last != w_is_last_idx);
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end else if ((r_state == DONE) && out_ready) begin
            r_len_err <= 1'b0;
         end
      end
   end

   assign score_ready = r_score_ready;
   assign out_valid   = r_out_valid;
   assign class_out   = r_class_out;
   assign max_score   = r_max_score;
   assign margin      = r_margin;
   assign len_err     = r_len_err;
   assign frame_cnt   = r_frame_cnt;

endmodule
